// File: rtl/cpu_pkg.sv
// Shared CPU definitions: status flag bit positions and branch condition encodings.
// Used by the writeback stage and by anything that decodes status or cond_sel.
package cpu_pkg;

  localparam int FLAG_CARRY = 2;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_ZERO   = 2'b01,
    COND_NEG    = 2'b10,
    COND_CARRY  = 2'b11
  } cond_e;

  function automatic logic eval_cond(input logic [2:0] flags, input logic [1:0] sel);
    logic res;
    case (cond_e'(sel))
      COND_ALWAYS: res = 1'b1;
      COND_ZERO:   res = flags[FLAG_ZERO];
      COND_NEG:    res = flags[FLAG_NEG];
      COND_CARRY:  res = flags[FLAG_CARRY];
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; the caller must only write when there is room
// (or a read happens in the same cycle) and only read when not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage and pointers; memory is cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy; simultaneous read and write leave it unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: queues captured results for the register file, keeps the status
// flags, flags dropped captures, and evaluates branch conditions on the status register.
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int DEPTH      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  capture,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [2:0]            alu_flags,
  input  logic [REG_ADDR_W-1:0] dest_addr,
  input  logic                  flag_we,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [2:0]            status,
  output logic                  full,
  output logic                  overflow,
  input  logic [1:0]            cond_sel,
  output logic                  cond_true
);

  localparam int ENTRY_W = DATA_W + REG_ADDR_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               pop_s;
  logic               accept_s;
  logic               empty_s;
  logic               full_s;
  logic [CNT_W-1:0]   count_s;
  logic [ENTRY_W-1:0] head_s;
  logic [2:0]         status_r;
  logic               overflow_r;

  assign pop_s    = wb_valid & wb_ready;
  // A pop in the same cycle frees the slot the new capture needs.
  assign accept_s = capture & ((count_s != CNT_W'(DEPTH)) | pop_s);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (accept_s),
    .rd_en (pop_s),
    .wdata ({alu_result, dest_addr}),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Status flags load only with an accepted capture; overflow is sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      status_r   <= 3'b000;
      overflow_r <= 1'b0;
    end else begin
      if (accept_s && flag_we) begin
        status_r <= alu_flags;
      end
      if (capture && !accept_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Branch condition decode.
  always_comb begin
    cond_true = 1'b0;
    cond_true = eval_cond(status_r, cond_sel);
  end

  assign wb_valid = ~empty_s;
  assign wb_data  = head_s[ENTRY_W-1:REG_ADDR_W];
  assign wb_addr  = head_s[REG_ADDR_W-1:0];
  assign full     = full_s;
  assign status   = status_r;
  assign overflow = overflow_r;

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
Parameters:
REQ-001 SHALL have DATA_W, default 8, ALU result width.
REQ-002 SHALL have REG_ADDR_W, default 3, register-file address width.
REQ-003 SHALL have DEPTH, default 2, writeback queue entries (power of two, >=2).
Ports:
REQ-004 SHALL have clock  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have capture  input  1  strobe: ALU output bus holds a valid result this cycle.
REQ-007 SHALL have alu_result  input  DATA_W  ALU output bus.
REQ-008 SHALL have alu_flags  input  3  {carry, negative, zero}, MSB to LSB.
REQ-009 SHALL have dest_addr  input  REG_ADDR_W  destination register for the captured result.
REQ-010 SHALL have flag_we  input  1  update status register on this capture.
REQ-011 SHALL have wb_valid  output  1  queue head is presented to the register file.
REQ-012 SHALL have wb_ready  input  1  register file accepts the head this cycle.
REQ-013 SHALL have wb_data  output  DATA_W  head result.
REQ-014 SHALL have wb_addr  output  REG_ADDR_W  head destination.
REQ-015 SHALL have status  output  3  registered {carry, negative, zero}.
REQ-016 SHALL have full  output  1  queue holds DEPTH entries.
REQ-017 SHALL have overflow  output  1  sticky: capture was dropped.
REQ-018 SHALL have cond_sel  input  2  condition select for branch unit.
REQ-019 SHALL have cond_true  output  1  selected condition evaluated on status.

Function
REQ-020 Capture accepted when capture=1 and (full=0 or pop this cycle); {alu_result, dest_addr} enqueued at that edge.
REQ-021 Pop occurs when wb_valid=1 and wb_ready=1; head removed at that edge.
REQ-022 Latency: accepted capture into empty queue SHALL give wb_valid=1 in the following cycle with that data/address.
REQ-023 wb_data and wb_addr SHALL remain stable while wb_valid=1 and wb_ready=0.
REQ-024 Capture on full with simultaneous pop SHALL be accepted; count unchanged.
REQ-025 Capture on full without pop SHALL be dropped, status unchanged, overflow set to 1 and held until reset.
REQ-026 Capture and pop together on non-full, non-empty queue: count unchanged, order preserved (FIFO).
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-028 On accepted capture with flag_we=1, status SHALL load alu_flags at the same edge; flag_we=0 or dropped capture leaves status unchanged.
REQ-029 cond_true combinational from status: cond_sel 00 -> 1, 01 -> zero, 10 -> negative, 11 -> carry.
REQ-030 wb_valid=0 when queue empty; wb_data/wb_addr then hold last popped value (don't-care for checking).
REQ-031 capture SHALL only be asserted while the ALU drives its bus; undriven-bus capture is a system protocol violation, not handled here.

Reset
REQ-032 reset=1 at a rising edge SHALL clear count, pointers, status=3'b000, overflow=0, wb_valid=0, full=0, wb_data=0, wb_addr=0.
REQ-033 reset mid-operation SHALL discard all queued entries; capture/wb_ready in the reset cycle are ignored.
REQ-034 First capture accepted at the first edge after reset deasserts.

Structure
REQ-035 Flag bit indices (CARRY=2, NEG=1, ZERO=0) and cond_sel encodings SHALL live in shared package cpu_pkg.
REQ-036 Queue SHALL be a sub-module sync_fifo (parameterised width, depth, count/full/empty); status, overflow and condition logic in alu_writeback.

Verification
REQ-037 Reset, capture 8'h3C addr 3 flags 3'b000 flag_we=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=8'h3C, wb_addr=3, status=000; one cycle later wb_valid=0.
REQ-038 wb_ready=0, capture 8'h01 then 8'h02 -> full=1; third capture 8'h03 -> dropped, overflow=1; release wb_ready -> pops 01 then 02 only.
REQ-039 Full queue, capture 8'hAA with wb_ready=1 -> head popped, 8'hAA accepted, full stays 1, order preserved.
REQ-040 Capture flags 3'b101 flag_we=1 then flags 3'b010 flag_we=0 -> status=101; cond_sel 01->1, 10->0, 11->1, 00->1.
REQ-041 Two entries queued, assert reset one cycle -> wb_valid=0, status=000, overflow=0; next capture 8'h55 emerges as sole entry.
REQ-042 Continuous capture every cycle with wb_ready=1 for 20 cycles, values 0..19 -> all 20 written back in order, overflow=0.
